// File: rtl/gpio_irq.sv
// gpio_irq: parametrised GPIO with direction/output control, synchronised
// inputs and per-pin edge interrupt capture (write-1-to-clear status).
// Sits on the mem_cmd/mem_rsp peripheral bus; read responses are registered.
module gpio_irq #(
   parameter int                  NR_GPIOS    = 8,
   parameter int                  SYNC_STAGES = 2,
   parameter logic [NR_GPIOS-1:0] DOUT_RESET  = {NR_GPIOS{1'b0}}
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic                mem_cmd_sel,
   input  logic                mem_cmd_valid,
   input  logic                mem_cmd_wr,
   input  logic [11:0]         mem_cmd_addr,
   input  logic [31:0]         mem_cmd_wdata,
   output logic [31:0]         mem_rsp_rdata,
   output logic                mem_rsp_ready,
   output logic [NR_GPIOS-1:0] gpio_oe,
   output logic [NR_GPIOS-1:0] gpio_do,
   input  logic [NR_GPIOS-1:0] gpio_di,
   output logic                irq
);

   // Register word indices (byte offset / 4)
   localparam logic [3:0] REG_CONFIG   = 4'h0;
   localparam logic [3:0] REG_DOUT     = 4'h1;
   localparam logic [3:0] REG_DOUT_SET = 4'h2;
   localparam logic [3:0] REG_DOUT_CLR = 4'h3;
   localparam logic [3:0] REG_DOUT_TGL = 4'h4;
   localparam logic [3:0] REG_DIN      = 4'h5;
   localparam logic [3:0] REG_RISE_EN  = 4'h6;
   localparam logic [3:0] REG_FALL_EN  = 4'h7;
   localparam logic [3:0] REG_STATUS   = 4'h8;
   localparam logic [3:0] REG_MASK     = 4'h9;

   localparam logic [NR_GPIOS-1:0] ZERO = {NR_GPIOS{1'b0}};

   logic [NR_GPIOS-1:0] sync_r [SYNC_STAGES];
   logic [NR_GPIOS-1:0] din_s;
   logic [NR_GPIOS-1:0] din_p_r;
   logic [NR_GPIOS-1:0] rise_s;
   logic [NR_GPIOS-1:0] fall_s;

   logic [NR_GPIOS-1:0] oe_r, do_r, rise_en_r, fall_en_r, mask_r, status_r;
   logic [NR_GPIOS-1:0] oe_next_s, do_next_s, rise_en_next_s, fall_en_next_s, mask_next_s;
   logic [NR_GPIOS-1:0] clr_s, status_next_s, rd_val_s, wd_s;
   logic [31:0]         rdata_s;
   logic [31:0]         rsp_rdata_r;
   logic                rsp_ready_r;
   logic                irq_r;
   logic                wr_s, rd_s;
   logic [3:0]          reg_idx_s;
   logic                unused_bits;

   assign wr_s      = mem_cmd_valid & mem_cmd_sel & mem_cmd_wr;
   assign rd_s      = mem_cmd_valid & mem_cmd_sel & ~mem_cmd_wr;
   assign reg_idx_s = mem_cmd_addr[5:2];
   assign wd_s      = mem_cmd_wdata[NR_GPIOS-1:0];
   // Address bits outside [5:2] and write data above the pin count are don't-care
   assign unused_bits = ^{mem_cmd_addr[11:6], mem_cmd_addr[1:0], mem_cmd_wdata};

   assign din_s  = sync_r[SYNC_STAGES-1];
   assign rise_s = din_s & ~din_p_r;
   assign fall_s = ~din_s & din_p_r;

   // Input synchroniser chain plus one delay flop for edge detection
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= ZERO;
         din_p_r <= ZERO;
      end else begin
         sync_r[0] <= gpio_di;
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
         din_p_r <= din_s;
      end
   end

   // Register write decode: next values of control registers and W1C mask
   always_comb begin
      oe_next_s      = oe_r;
      do_next_s      = do_r;
      rise_en_next_s = rise_en_r;
      fall_en_next_s = fall_en_r;
      mask_next_s    = mask_r;
      clr_s          = ZERO;
      if (wr_s) begin
         case (reg_idx_s)
            REG_CONFIG:   oe_next_s      = wd_s;
            REG_DOUT:     do_next_s      = wd_s;
            REG_DOUT_SET: do_next_s      = do_r | wd_s;
            REG_DOUT_CLR: do_next_s      = do_r & ~wd_s;
            REG_DOUT_TGL: do_next_s      = do_r ^ wd_s;
            REG_RISE_EN:  rise_en_next_s = wd_s;
            REG_FALL_EN:  fall_en_next_s = wd_s;
            REG_STATUS:   clr_s          = wd_s;
            REG_MASK:     mask_next_s    = wd_s;
            default:      clr_s          = ZERO;
         endcase
      end else begin
         clr_s = ZERO;
      end
   end

   // Status next state: captured edges (old enables) win over a same-cycle clear
   always_comb begin
      status_next_s = (status_r & ~clr_s) | (rise_s & rise_en_r) | (fall_s & fall_en_r);
   end

   // Read mux over the pre-write register state, zero-extended to 32 bits
   always_comb begin
      case (reg_idx_s)
         REG_CONFIG:  rd_val_s = oe_r;
         REG_DOUT:    rd_val_s = do_r;
         REG_DIN:     rd_val_s = din_s;
         REG_RISE_EN: rd_val_s = rise_en_r;
         REG_FALL_EN: rd_val_s = fall_en_r;
         REG_STATUS:  rd_val_s = status_r;
         REG_MASK:    rd_val_s = mask_r;
         default:     rd_val_s = ZERO;
      endcase
      rdata_s = 32'h0000_0000;
      rdata_s[NR_GPIOS-1:0] = rd_val_s;
   end

   // Register file, status, interrupt line and registered read response
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         oe_r        <= ZERO;
         do_r        <= DOUT_RESET;
         rise_en_r   <= ZERO;
         fall_en_r   <= ZERO;
         mask_r      <= ZERO;
         status_r    <= ZERO;
         irq_r       <= 1'b0;
         rsp_ready_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
      end else begin
         oe_r        <= oe_next_s;
         do_r        <= do_next_s;
         rise_en_r   <= rise_en_next_s;
         fall_en_r   <= fall_en_next_s;
         mask_r      <= mask_next_s;
         status_r    <= status_next_s;
         irq_r       <= |(status_next_s & mask_next_s);
         rsp_ready_r <= rd_s;
         if (rd_s) begin
            rsp_rdata_r <= rdata_s;
         end else begin
            rsp_rdata_r <= rsp_rdata_r;
         end
      end
   end

   assign gpio_oe       = oe_r;
   assign gpio_do       = do_r;
   assign irq           = irq_r;
   assign mem_rsp_ready = rsp_ready_r;
   assign mem_rsp_rdata = rsp_rdata_r;

endmodule
